// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: merges non-stallable ALU results with
// buffered long-latency results and tracks pending destinations (busy bits).
module rf_writeback_arbiter #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_wdata,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_wdata,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   output logic [31:0]     busy,
   output logic            rf_en,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] wdata,
   output logic            hazard_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_ent_t;

   wb_ent_t         mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   wb_ent_t         head;
   logic            fifo_empty, push, pop;

   logic            sel_vld;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic [31:0]     busy_nxt;

   assign head       = mem[rd_ptr];
   assign fifo_empty = (count == '0);
   // Ready reflects occupancy only; a full FIFO refuses even while popping.
   assign lsu_ready  = (count < CW'(FIFO_DEPTH));
   assign push       = lsu_valid & lsu_ready;
   // ALU has absolute priority; the FIFO head only drains on ALU-idle cycles.
   assign pop        = ~alu_valid & ~fifo_empty;

   // Write-port source selection.
   always_comb begin
      sel_vld  = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (alu_valid) begin
         sel_vld  = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_wdata;
      end else if (pop) begin
         sel_vld  = 1'b1;
         sel_rd   = head.rd;
         sel_data = head.data;
      end
   end

   // Scoreboard next state: pop clears, issue sets afterwards so set wins.
   always_comb begin
      busy_nxt = busy;
      if (pop)
         busy_nxt[head.rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0)
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_wdata};
   end

   // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered write port, scoreboard and hazard flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_en      <= 1'b0;
         rd         <= '0;
         wdata      <= '0;
         busy       <= '0;
         hazard_err <= 1'b0;
      end else begin
         // x0 writes still consume their slot but never reach the file.
         rf_en      <= sel_vld & (sel_rd != 5'd0);
         if (sel_vld) begin
            rd    <= sel_rd;
            wdata <= sel_data;
         end
         busy       <= busy_nxt;
         hazard_err <= alu_valid & (alu_rd != 5'd0) & busy[alu_rd];
      end
   end

endmodule
